// File: rtl/selector_arb.sv
// Selects one of N valid/ready input channels (fixed SEL or round-robin) into a
// single registered output slot that drains and reloads in the same cycle.
module selector_arb #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mode_i,
  input  logic [$clog2(N)-1:0]   sel_i,
  input  logic [N*W-1:0]         in_data_i,
  input  logic [N-1:0]           in_valid_i,
  output logic [N-1:0]           in_ready_o,
  output logic [W-1:0]           out_data_o,
  output logic [$clog2(N)-1:0]   out_ch_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);
  localparam int CW = $clog2(N);

  logic [W-1:0]  data_q,  data_d;
  logic [CW-1:0] ch_q,    ch_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] ptr_q,   ptr_d;

  logic          load;
  logic          gnt_vld;
  logic [CW-1:0] gnt_idx;
  logic          xfer;

  assign load = !valid_q || out_ready_i;

  // Round-robin search starts just after the last granted channel and ends on it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!mode_i) begin
      if (int'(sel_i) < N && in_valid_i[sel_i]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel_i;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!gnt_vld && in_valid_i[(int'(ptr_q) + k) % N]) begin
          gnt_vld = 1'b1;
          gnt_idx = CW'((int'(ptr_q) + k) % N);
        end
      end
    end
  end

  assign xfer = load && !rst_i && gnt_vld;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready_o[i] = xfer && (gnt_idx == CW'(i));
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = in_data_i[int'(gnt_idx)*W +: W];
      ch_d    = gnt_idx;
      valid_d = 1'b1;
      ptr_d   = gnt_idx;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= CW'(N-1);
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;
  assign out_valid_o = valid_q;
endmodule

// File: tb/tb_selector_arb.sv
// Directed bench for selector_arb: behavioural model checked every cycle plus
// literal expectations for the documented scenarios.
module tb_selector_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_valid;
  logic           out_ready;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // model state
  bit       mv;
  int       md, mc, mp;

  selector_arb #(.N(N), .W(W)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sel_i(sel),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_ch_o(out_ch), .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int grant(input bit m, input int s, input logic [N-1:0] v, input int p);
    if (!m) return (s < N && v[s]) ? s : -1;
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = grant(mode, int'(sel), in_valid, mp);
    if (rst || !(!mv || out_ready) || g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int g;
    if (rst) begin
      mv = 0; md = 0; mc = 0; mp = N-1;
    end else if (!mv || out_ready) begin
      g = grant(mode, int'(sel), in_valid, mp);
      if (g >= 0) begin
        md = int'(in_data[g*W +: W]); mc = g; mv = 1; mp = g;
      end else begin
        mv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model out_valid", int'(out_valid), int'(mv));
      chk("model out_data", int'(out_data), md);
      chk("model out_ch", int'(out_ch), mc);
      chk("model in_ready", int'(in_ready), int'(exp_ready()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; mode = 0; sel = 0; out_ready = 1;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'hF;
    tick(); tick();
    chk_en = 1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset out_ch", int'(out_ch), 0);
    chk("reset in_ready", int'(in_ready), 0);

    // fixed select walk
    rst = 0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      chk("m0 data", int'(out_data), 8'h11 * (s + 1));
      chk("m0 ch", int'(out_ch), s);
      chk("m0 valid", int'(out_valid), 1);
    end

    // round-robin after reset, all valid
    rst = 1; tick(); rst = 0; mode = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr onehot", int'($onehot(in_ready)), 1);
      tick();
      chk("rr ch", int'(out_ch), k % 4);
    end

    // backpressure holds the slot
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp in_ready", int'(in_ready), 0);
      tick();
      chk("bp data", int'(out_data), 8'h44);
      chk("bp ch", int'(out_ch), 3);
      chk("bp valid", int'(out_valid), 1);
    end
    out_ready = 1;
    tick();
    chk("bp release ch", int'(out_ch), 0);
    chk("bp release data", int'(out_data), 8'h11);

    // sparse round-robin then drain
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sparse ch", int'(out_ch), (k % 2) ? 3 : 1);
    end
    in_valid = 4'b0000;
    tick();
    chk("sparse drain valid", int'(out_valid), 0);
    chk("sparse drain ch hold", int'(out_ch), 3);

    // reset mid-stream
    in_valid = 4'hF;
    tick();
    chk("pre-rst valid", int'(out_valid), 1);
    rst = 1; tick();
    chk("rst valid", int'(out_valid), 0);
    rst = 0; tick();
    chk("post-rst ch", int'(out_ch), 0);

    // mode switch resumes after last transferred channel
    mode = 0; sel = 2; tick();
    chk("switch m0 ch", int'(out_ch), 2);
    mode = 1; tick();
    chk("switch m1 ch", int'(out_ch), 3);

    // fixed select on an invalid channel
    mode = 0; sel = 2; in_valid = 4'b1011;
    #1;
    chk("sel invalid ready", int'(in_ready), 0);
    tick();
    chk("sel invalid valid", int'(out_valid), 0);

    // mixed traffic, checked by the model each cycle
    for (int k = 0; k < 60; k++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 29) == 0);
      tick();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
